// File: rtl/gpsclock_testgen.sv
// Synthetic PPS generator with programmable period, width and one-shot phase jump,
// plus a snapshot FIFO that records the clock core status on each local PPS edge.
module gpsclock_testgen #(
  parameter int          DW         = 32,
  parameter int          RW         = 64,
  parameter int          LGFIFO     = 4,
  parameter logic [31:0] DEF_PERIOD = 32'd81200000,
  parameter logic [31:0] DEF_PWIDTH = 32'd8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_lcl_pps,
  input  logic          i_wb_cyc_stb,
  input  logic          i_wb_we,
  input  logic [3:0]    i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [DW-1:0] o_wb_data,
  input  logic [RW-1:0] i_err,
  input  logic [RW-1:0] i_count,
  input  logic [RW-1:0] i_step,
  output logic          o_pps
);

  localparam int SW = 32 + 3*RW;
  localparam logic [LGFIFO:0] DEPTH = (LGFIFO+1)'(1 << LGFIFO);

  // Wishbone handshake: every cycle with i_wb_cyc_stb high is one transaction,
  // never stalled; o_wb_ack follows one clock later with o_wb_data valid alongside.
  logic wb_wr;
  logic wr_period, wr_jump, wr_pwidth, wr_ctrl, pop_req;

  assign wb_wr     = i_wb_cyc_stb & i_wb_we;
  assign wr_period = wb_wr && (i_wb_addr == 4'd0);
  assign wr_jump   = wb_wr && (i_wb_addr == 4'd1);
  assign wr_pwidth = wb_wr && (i_wb_addr == 4'd2);
  assign wr_ctrl   = wb_wr && (i_wb_addr == 4'd3);
  assign pop_req   = wb_wr && (i_wb_addr == 4'd11);
  assign o_wb_stall = 1'b0;

  logic [31:0] r_period, r_pwidth, r_jump;
  logic        r_enable, r_jump_vld;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_period   <= DEF_PERIOD;
      r_pwidth   <= DEF_PWIDTH;
      r_enable   <= 1'b1;
      r_jump     <= '0;
      r_jump_vld <= 1'b0;
    end else begin
      r_jump_vld <= wr_jump;
      if (wr_period) r_period <= i_wb_data[31:0];
      if (wr_pwidth) r_pwidth <= i_wb_data[31:0];
      if (wr_jump)   r_jump   <= i_wb_data[31:0];
      if (wr_ctrl)   r_enable <= i_wb_data[0];
    end
  end

  // PPS generator
  logic [31:0] r_ctr, r_pulse, r_pps_count, ctr_next;
  logic        wrap;
  logic [32:0] ctr_sum;

  assign wrap = (r_ctr >= (r_period - 32'd1));

  // 33-bit two's-complement sum; a negative result (jump past zero) clamps to 0
  always_comb begin
    ctr_sum = {1'b0, r_ctr} + 33'd1;
    if (wrap)       ctr_sum = ctr_sum - {1'b0, r_period};
    if (r_jump_vld) ctr_sum = ctr_sum + {r_jump[31], r_jump};
    ctr_next = ctr_sum[32] ? 32'd0 : ctr_sum[31:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ctr       <= '0;
      r_pulse     <= '0;
      r_pps_count <= '0;
    end else if (!r_enable) begin
      r_ctr   <= '0;
      r_pulse <= '0;
    end else begin
      r_ctr <= ctr_next;
      if (wrap) begin
        r_pulse     <= (r_pwidth == 32'd0) ? 32'd1 : r_pwidth;
        r_pps_count <= r_pps_count + 32'd1;
      end else if (r_pulse != 32'd0) begin
        r_pulse <= r_pulse - 32'd1;
      end
    end
  end

  assign o_pps = r_enable & (r_pulse != 32'd0);

  // Snapshot capture: latch on the rising edge, push one clock later
  logic [31:0]   lcl_counter;
  logic          prev_pps, push_pend, lcl_edge;
  logic [SW-1:0] snap_data;

  assign lcl_edge = i_lcl_pps & ~prev_pps;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lcl_counter <= '0;
      prev_pps    <= 1'b0;
      push_pend   <= 1'b0;
      snap_data   <= '0;
    end else begin
      lcl_counter <= lcl_counter + 32'd1;
      prev_pps    <= i_lcl_pps;
      push_pend   <= lcl_edge;
      if (lcl_edge) snap_data <= {lcl_counter, i_err, i_count, i_step};
    end
  end

  // Snapshot FIFO
  logic [SW-1:0]   mem [0:(1<<LGFIFO)-1];
  logic [LGFIFO:0] wr_ptr, rd_ptr, fill;
  logic            empty, full, ovf;
  logic            do_flush, clr_ovf, do_pop, do_push;

  assign fill     = wr_ptr - rd_ptr;
  assign empty    = (fill == '0);
  assign full     = (fill == DEPTH);
  assign do_flush = wr_ctrl & i_wb_data[1];
  assign clr_ovf  = wr_ctrl & i_wb_data[2];
  assign do_pop   = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push  = push_pend & (~full | do_pop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (do_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (push_pend && !do_push) ovf <= 1'b1;
      else if (clr_ovf)          ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !do_flush) mem[wr_ptr[LGFIFO-1:0]] <= snap_data;
  end

  logic [SW-1:0] head;
  logic [31:0]   h_lcl;
  logic [RW-1:0] h_err, h_count, h_step;
  logic [31:0]   status;
  logic [DW-1:0] rd_mux;

  assign head    = mem[rd_ptr[LGFIFO-1:0]];
  assign h_lcl   = head[SW-1:3*RW];
  assign h_err   = head[3*RW-1:2*RW];
  assign h_count = head[2*RW-1:RW];
  assign h_step  = head[RW-1:0];

  always_comb begin
    status = '0;
    status[0] = r_enable;
    status[8 +: LGFIFO+1] = fill;
    status[16] = ovf;
    status[17] = empty;
  end

  always_comb begin
    rd_mux = '0;
    case (i_wb_addr)
      4'd0:  rd_mux = DW'(r_period);
      4'd1:  rd_mux = DW'(r_pps_count);
      4'd2:  rd_mux = DW'(r_pwidth);
      4'd3:  rd_mux = DW'(status);
      4'd4:  if (!empty) rd_mux = DW'(h_lcl);
      4'd5:  if (!empty) rd_mux = DW'(h_err >> DW);
      4'd6:  if (!empty) rd_mux = DW'(h_err);
      4'd7:  if (!empty) rd_mux = DW'(h_count >> DW);
      4'd8:  if (!empty) rd_mux = DW'(h_count);
      4'd9:  if (!empty) rd_mux = DW'(h_step >> DW);
      4'd10: if (!empty) rd_mux = DW'(h_step);
      4'd11: rd_mux = DW'(fill);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= i_wb_cyc_stb;
      if (i_wb_cyc_stb) o_wb_data <= rd_mux;
    end
  end

endmodule
